// File: rtl/acc_bundle_serializer_if.sv
// acc_bundle_serializer_if: bundle input and 64-bit word stream output of the serializer
// bundle_valid/bundle_ready/bundle_data: parallel bundle handshake, element i at [i*ELEM_W +: ELEM_W]
// out_valid/out_ready/out_data/out_last: serial word stream toward the producer FIFO
// master: the side that supplies bundles and sinks words; slave: the serializer
interface acc_bundle_serializer_if #(
  parameter int NUM_WORDS = 128,
  parameter int ELEM_W = 32
);
  logic bundle_valid;
  logic bundle_ready;
  logic [NUM_WORDS*ELEM_W-1:0] bundle_data;
  logic out_valid;
  logic out_ready;
  logic [63:0] out_data;
  logic out_last;
  modport master (
    output bundle_valid, bundle_data, out_ready,
    input bundle_ready, out_valid, out_data, out_last
  );
  modport slave (
    input bundle_valid, bundle_data, out_ready,
    output bundle_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/acc_bundle_serializer.sv
// acc_bundle_serializer: captures a parallel result bundle and replays it as 64-bit valid/ready words
// clk, rst_n: clock and asynchronous active-low reset; flush: synchronous abort of the current bundle
// cfg_len, cfg_sext: words per bundle (0 or oversized = NUM_WORDS) and sign-extend mode, sampled at accept
// bus: bundle handshake in, word stream out (slave modport)
// busy: a bundle is being sent; done: one-cycle pulse after the final word handshake
module acc_bundle_serializer #(
  parameter int NUM_WORDS = 128,
  parameter int ELEM_W = 32,
  parameter int LEN_W = $clog2(NUM_WORDS) + 1
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic [LEN_W-1:0] cfg_len,
  input logic cfg_sext,
  acc_bundle_serializer_if.slave bus,
  output logic busy,
  output logic done
);
  localparam int IDX_W = LEN_W - 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(NUM_WORDS);
  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt, cnt_nx, len_r, len_in;
  logic sext_r, done_nx, accept, hs, last;
  logic [ELEM_W-1:0] buf_r [NUM_WORDS];
  logic [ELEM_W-1:0] elem;
  logic [63:0] ext;
  assign accept = state == S_IDLE && bus.bundle_valid && !flush;
  assign hs = state == S_SEND && bus.out_ready;
  assign last = state == S_SEND && cnt == len_r - 1'b1;
  assign len_in = (cfg_len == '0 || cfg_len > FULL) ? FULL : cfg_len;
  assign elem = buf_r[cnt[IDX_W-1:0]];
  generate
    if (ELEM_W < 64) begin : g_ext
      assign ext = {{(64-ELEM_W){sext_r & elem[ELEM_W-1]}}, elem};
    end else begin : g_pass
      assign ext = elem;
    end
  endgenerate
  // bundle_ready also drops while rst_n is held low so nothing is offered during reset
  assign bus.bundle_ready = state == S_IDLE && rst_n;
  assign bus.out_valid = state == S_SEND;
  assign bus.out_data = state == S_SEND ? ext : '0;
  assign bus.out_last = last;
  assign busy = state != S_IDLE;
  always_comb begin
    state_nx = flush ? S_IDLE : accept ? S_SEND : (hs && last) ? S_IDLE : state;
    cnt_nx = (flush || accept || (hs && last)) ? '0 : hs ? cnt + 1'b1 : cnt;
    done_nx = hs && last && !flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      len_r <= FULL;
      sext_r <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      done <= done_nx;
      if (accept) begin
        len_r <= len_in;
        sext_r <= cfg_sext;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < NUM_WORDS; i++) buf_r[i] <= bus.bundle_data[i*ELEM_W +: ELEM_W];
  end
endmodule

// File: tb/tb_acc_bundle_serializer.sv
// tb_acc_bundle_serializer: scoreboard bench for the bundle serializer
module tb_acc_bundle_serializer;
  localparam int NW = 128;
  localparam int EW = 32;
  localparam int LW = $clog2(NW) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cfg_sext = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic busy, done;
  int errs = 0;
  int checks = 0;
  int pops = 0;
  int p0;
  int pat[5] = '{1, 0, 0, 1, 1};
  logic [64:0] exp_q[$];
  logic [64:0] e;
  logic [EW-1:0] elems [NW];
  logic exp_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  acc_bundle_serializer_if #(.NUM_WORDS(NW), .ELEM_W(EW)) bus ();
  acc_bundle_serializer #(.NUM_WORDS(NW), .ELEM_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_len(cfg_len), .cfg_sext(cfg_sext),
    .bus(bus), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ext(input logic [EW-1:0] v, input logic s);
    return s ? 64'($signed(v)) : 64'(v);
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic send(input int len, input logic s);
    int n;
    for (int i = 0; i < NW; i++) bus.bundle_data[i*EW +: EW] = elems[i];
    cfg_len = LW'(len);
    cfg_sext = s;
    n = (len == 0 || len > NW) ? NW : len;
    for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), ext(elems[i], s)});
    bus.bundle_valid = 1'b1;
    tick();
    bus.bundle_valid = 1'b0;
    cfg_len = LW'(1);
    cfg_sext = ~s;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", done, exp_done);
      if (prev_stall) begin
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_valid", bus.out_valid, 1);
      end
      if (!bus.out_valid) chk("idle_zero", bus.out_data, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("word", bus.out_data, e[63:0]);
          chk("last", bus.out_last, 64'(e[64]));
          pops++;
        end
      end
      exp_done = bus.out_valid && bus.out_ready && bus.out_last && !flush;
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_data = bus.out_data;
    end
  end
  initial begin
    bus.bundle_valid = 1'b0;
    bus.bundle_data = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_bundle_ready_low", bus.bundle_ready, 0);
    chk("rst_valid_low", bus.out_valid, 0);
    tick();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_bundle_ready", bus.bundle_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int i = 0; i < NW; i++) elems[i] = EW'(i);
    bus.out_ready = 1'b1;
    send(0, 1'b0);
    chk("latency_valid", bus.out_valid, 1);
    chk("send_ready_low", bus.bundle_ready, 0);
    wait_idle();
    chk("full_q_empty", exp_q.size(), 0);
    chk("full_ready_back", bus.bundle_ready, 1);
    for (int i = 0; i < NW; i++) elems[i] = EW'(32'hA + i);
    send(3, 1'b0);
    for (int j = 0; j < 5; j++) begin
      bus.out_ready = pat[j][0];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle();
    chk("short_q_empty", exp_q.size(), 0);
    elems[0] = 32'h8000_0001;
    bus.out_ready = 1'b0;
    send(1, 1'b1);
    chk("sext_word", bus.out_data, 64'hFFFF_FFFF_8000_0001);
    chk("sext_last", bus.out_last, 1);
    bus.out_ready = 1'b1;
    wait_idle();
    bus.out_ready = 1'b0;
    send(1, 1'b0);
    chk("zext_word", bus.out_data, 64'h0000_0000_8000_0001);
    bus.out_ready = 1'b1;
    wait_idle();
    chk("ext_q_empty", exp_q.size(), 0);
    for (int i = 0; i < NW; i++) elems[i] = EW'(i);
    send(0, 1'b0);
    p0 = pops;
    tick(5);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_pops", pops - p0, 5);
    exp_q.delete();
    tick(2);
    bus.bundle_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.bundle_valid = 1'b0;
    chk("flush_idle_no_accept", busy, 0);
    for (int i = 0; i < NW; i++) elems[i] = EW'(32'hFFFF_FF00 + i);
    bus.out_ready = 1'b1;
    send(4, 1'b1);
    wait_idle();
    chk("after_flush_q_empty", exp_q.size(), 0);
    for (int i = 0; i < NW; i++) elems[i] = EW'(i * 7);
    send(0, 1'b0);
    tick(40);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ready", bus.bundle_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", bus.out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ready", bus.bundle_ready, 1);
    tick(5);
    chk("postrst_busy", busy, 0);
    for (int i = 0; i < NW; i++) elems[i] = EW'(i * 3 + 1);
    send(200, 1'b1);
    wait_idle();
    chk("oversize_q_empty", exp_q.size(), 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
